// File: rtl/memx_ctrl_pkg.sv
// Shared types and constants for the memX stream sequencer.
package memx_ctrl_pkg;

    localparam int MEMX_ADDR_W = 20;
    localparam int MEMX_DEPTH  = 1001;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_e;

endpackage

// File: rtl/memx_stream_sequencer_if.sv
// Control/address bundle between solver control, the sequencer and memX.
interface memx_stream_sequencer_if
    import memx_ctrl_pkg::*;
#(
    parameter int AW = MEMX_ADDR_W
) ();

    logic          start;
    logic [AW-1:0] base_address;
    logic [AW-1:0] row_count;
    logic [AW-1:0] read_address;
    logic          row_valid;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic          busy;
    logic          done;
    logic          range_error;

    // Solver control side: requests passes, observes progress.
    modport master (
        output start, base_address, row_count,
        input  read_address, row_valid, write_enable, write_address,
               busy, done, range_error
    );

    // Sequencer side.
    modport slave (
        input  start, base_address, row_count,
        output read_address, row_valid, write_enable, write_address,
               busy, done, range_error
    );

endinterface

// File: rtl/memx_delay_line.sv
// {valid, address} shift register that delays each read to its write-back slot.
module memx_delay_line
    import memx_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEMX_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              any_pending_o
);

    // Every stage except the output one: these are still inside after the next shift.
    localparam logic [DEPTH-1:0] KEEP_MASK = {DEPTH{1'b1}} >> 1;

    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;

    // Shift one stage per cycle; reset discards every in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            addr_q <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                vld_q[k]  <= vld_q[k-1];
                addr_q[k] <= addr_q[k-1];
            end
            vld_q[0]  <= in_valid_i;
            addr_q[0] <= in_addr_i;
        end
    end

    assign out_valid_o = vld_q[DEPTH-1];
    assign out_addr_o  = addr_q[DEPTH-1];

    // Pending excludes the write being presented now, so the owner can leave
    // its drain state on the same cycle the last write-back goes out.
    assign any_pending_o = in_valid_i | (|(vld_q & KEEP_MASK));

endmodule

// File: rtl/memx_stream_sequencer.sv
// One pass over a contiguous memX row block: stream reads, delayed write-backs.
module memx_stream_sequencer
    import memx_ctrl_pkg::*;
#(
    parameter int memories_address_width = MEMX_ADDR_W,
    parameter int pipe_latency           = 4,
    parameter int mem_depth              = MEMX_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    memx_stream_sequencer_if.slave  bus
);

    localparam int AW = memories_address_width;
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(mem_depth);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] count_q, count_d;
    logic [AW-1:0] read_address_q, read_address_d;
    logic          row_valid_q, row_valid_d;
    logic          range_error_q, range_error_d;

    logic [AW:0]   end_row;
    logic          out_of_range;
    logic          dl_valid;
    logic [AW-1:0] dl_addr;
    logic          dl_pending;

    // One extra bit so base+count never wraps before the depth compare.
    assign end_row      = {1'b0, bus.base_address} + {1'b0, bus.row_count};
    assign out_of_range = end_row > DEPTH_LIM;

    // Next-state and next-output decode.
    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        count_d        = count_q;
        read_address_d = read_address_q;
        row_valid_d    = 1'b0;
        range_error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.row_count == '0) begin
                        state_d = DONE;
                    end else if (out_of_range) begin
                        range_error_d = 1'b1;
                    end else begin
                        state_d        = ISSUE;
                        count_d        = bus.row_count;
                        i_d            = '0;
                        read_address_d = bus.base_address;
                        row_valid_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // Last row is being presented; hold read_address from here on.
                if (i_q == count_q - ONE) begin
                    state_d = DRAIN;
                end else begin
                    i_d            = i_q + ONE;
                    read_address_d = read_address_q + ONE;
                    row_valid_d    = 1'b1;
                end
            end
            DRAIN: begin
                if (!dl_pending) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            i_q            <= '0;
            count_q        <= '0;
            read_address_q <= '0;
            row_valid_q    <= 1'b0;
            range_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            i_q            <= i_d;
            count_q        <= count_d;
            read_address_q <= read_address_d;
            row_valid_q    <= row_valid_d;
            range_error_q  <= range_error_d;
        end
    end

    memx_delay_line #(
        .ADDR_W (AW),
        .DEPTH  (pipe_latency)
    ) u_delay (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (row_valid_q),
        .in_addr_i     (read_address_q),
        .out_valid_o   (dl_valid),
        .out_addr_o    (dl_addr),
        .any_pending_o (dl_pending)
    );

    assign bus.read_address  = read_address_q;
    assign bus.row_valid     = row_valid_q;
    assign bus.write_enable  = dl_valid;
    assign bus.write_address = dl_addr;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == DONE);
    assign bus.range_error   = range_error_q;

endmodule

// File: tb/tb_memx_stream_sequencer.sv
// Three sequencers (latency 4, 2, 1) share one stimulus stream; a per-lane
// scoreboard holds the expected row, write, done and range_error events.
module tb_memx_stream_sequencer;
    import memx_ctrl_pkg::*;

    localparam int LANES = 3;
    localparam int LAT [LANES] = '{4, 2, 1};

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [MEMX_ADDR_W-1:0] base = '0;
    logic [MEMX_ADDR_W-1:0] cnt = '0;

    logic [LANES-1:0] rv, we, bsy, dn, rerr;
    logic [LANES-1:0][MEMX_ADDR_W-1:0] ra, wa;

    // queue index = lane*4 + kind; kind 0 row, 1 write, 2 done, 3 range_error
    ev_t sb [LANES*4][$];
    int  busy_from [LANES] = '{default: 0};
    int  busy_to   [LANES] = '{default: -1};
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memx_stream_sequencer_if bus [LANES] ();

    for (genvar g = 0; g < LANES; g++) begin : g_dut
        assign bus[g].start        = start;
        assign bus[g].base_address = base;
        assign bus[g].row_count    = cnt;
        assign rv[g]   = bus[g].row_valid;
        assign ra[g]   = bus[g].read_address;
        assign we[g]   = bus[g].write_enable;
        assign wa[g]   = bus[g].write_address;
        assign bsy[g]  = bus[g].busy;
        assign dn[g]   = bus[g].done;
        assign rerr[g] = bus[g].range_error;

        memx_stream_sequencer #(.pipe_latency(LAT[g])) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );
    end

    task automatic chk(input string tag, input int lane, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d cyc=%0d got=%0h exp=%0h", tag, lane, cyc, got, exp);
        end
    endtask

    function automatic void push(input int lane, input int kind, input int c, input int a);
        ev_t e;
        e.cyc  = c;
        e.addr = a;
        sb[lane*4+kind].push_back(e);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; record what each lane should do with it.
    task automatic start_pass(input int b, input int n);
        start = 1'b1;
        base  = MEMX_ADDR_W'(b);
        cnt   = MEMX_ADDR_W'(n);
        for (int g = 0; g < LANES; g++) begin
            if (cyc <= busy_to[g]) continue;
            if (n == 0) begin
                push(g, 2, cyc + 1, 0);
                busy_from[g] = cyc + 1;
                busy_to[g]   = cyc + 1;
            end else if (b + n > MEMX_DEPTH) begin
                push(g, 3, cyc + 1, 0);
            end else begin
                for (int k = 0; k < n; k++) begin
                    push(g, 0, cyc + 1 + k, b + k);
                    push(g, 1, cyc + 1 + LAT[g] + k, b + k);
                end
                push(g, 2, cyc + n + LAT[g] + 1, 0);
                busy_from[g] = cyc + 1;
                busy_to[g]   = cyc + n + LAT[g] + 1;
            end
        end
        step(1);
        start = 1'b0;
    endtask

    // Reset for one cycle mid-pass: anything expected after this cycle is void.
    task automatic mid_reset();
        rst = 1'b1;
        for (int q = 0; q < LANES*4; q++)
            while (sb[q].size() > 0 && sb[q][$].cyc > cyc) void'(sb[q].pop_back());
        for (int g = 0; g < LANES; g++)
            if (busy_to[g] > cyc) busy_to[g] = cyc;
        step(1);
        rst = 1'b0;
        for (int g = 0; g < LANES; g++) begin
            chk("ra_after_rst", g, ra[g], 0);
            chk("wa_after_rst", g, wa[g], 0);
        end
    endtask

    task automatic chk_ev(input string tag, input int g, input int kind, input logic obs, input int a);
        int   q = g*4 + kind;
        logic exp = (sb[q].size() > 0) && (sb[q][0].cyc == cyc);
        chk(tag, g, obs, exp);
        if (exp) begin
            if (kind < 2 && obs) chk({tag, "_addr"}, g, a, sb[q][0].addr);
            void'(sb[q].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < LANES; g++) begin
                chk_ev("row", g, 0, rv[g], ra[g]);
                chk_ev("wr", g, 1, we[g], wa[g]);
                chk_ev("done", g, 2, dn[g], 0);
                chk_ev("rerr", g, 3, rerr[g], 0);
                chk("busy", g, bsy[g], (cyc >= busy_from[g] && cyc <= busy_to[g]));
            end
        end
    end

    initial begin
        step(3);
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int g = 0; g < LANES; g++) begin
            chk("ra_reset", g, ra[g], 0);
            chk("wa_reset", g, wa[g], 0);
        end

        // basic pass
        start_pass(10, 3);
        step(12);

        // empty pass
        start_pass(0, 0);
        step(3);

        // range boundary: one past the end rejected, exactly to the end accepted
        start_pass(998, 4);
        step(3);
        start_pass(998, 3);
        step(12);

        // starts while busy / in the done cycle (latency-2 lane)
        start_pass(0, 5);
        step(1);
        start_pass(500, 2);
        step(5);
        start_pass(600, 2);
        step(14);

        // reset in the third cycle of a pass
        start_pass(20, 6);
        step(2);
        mid_reset();
        step(12);

        // latency-1 lane: single row, then back-to-back start right after done
        start_pass(0, 1);
        step(3);
        start_pass(7, 2);
        step(15);

        for (int q = 0; q < LANES*4; q++) chk("leftover", q / 4, sb[q].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
